// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, port indices
// and the default memory depth.
package mips_mem_pkg;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned PORT_CPU          = 0;
    localparam int unsigned PORT_DMA          = 1;
    localparam int unsigned DEFAULT_MEM_DEPTH = 100;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a lone requester always wins; on a tie the
// port selected by ptr wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = '0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory (CPU / DMA).
// Define DMEM_ARB_STATS_EN to add saturating grant/conflict counters.
module dmem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = DEFAULT_MEM_DEPTH
`ifdef DMEM_ARB_STATS_EN
    ,
    parameter int unsigned CNT_WIDTH  = 16
`endif
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [DATA_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  err0,
    output logic                  err1,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  gnt_cnt0,
    output logic [CNT_WIDTH-1:0]  gnt_cnt1,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
`endif
);

    localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(MEM_DEPTH);

    arb_state_e            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic [1:0]            rvalid_q, rvalid_d;
    logic [1:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q [2];
    logic [DATA_WIDTH-1:0] rdata_d [2];

    logic [1:0]            req_v, we_v, lock_v, rr_gnt, gnt_v;
    logic                  sel, granted, in_range;
    logic [DATA_WIDTH-1:0] addr_sel, wdata_sel;

    assign req_v[PORT_CPU]  = req0;
    assign req_v[PORT_DMA]  = req1;
    assign we_v[PORT_CPU]   = we0;
    assign we_v[PORT_DMA]   = we1;
    assign lock_v[PORT_CPU] = lock0;
    assign lock_v[PORT_DMA] = lock1;

    rr_arb2 u_rr_arb2 (
        .req (req_v),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt)
    );

    always_comb begin
        gnt_v = '0;
        if (RST) begin
            if (state_q == ST_LOCKED) gnt_v[owner_q] = req_v[owner_q];
            else                      gnt_v = rr_gnt;
        end
    end

    assign gnt0      = gnt_v[PORT_CPU];
    assign gnt1      = gnt_v[PORT_DMA];
    assign granted   = |gnt_v;
    assign sel       = gnt_v[PORT_DMA];
    assign addr_sel  = sel ? addr1 : addr0;
    assign wdata_sel = sel ? wdata1 : wdata0;
    assign in_range  = addr_sel < DEPTH_W;

    assign mem_a  = granted ? addr_sel : '0;
    assign mem_wd = granted ? wdata_sel : '0;
    assign mem_we = granted & we_v[sel] & in_range;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_ARB: begin
                if (granted) begin
                    rr_ptr_d = ~sel;
                    if (lock_v[sel]) begin
                        state_d = ST_LOCKED;
                        owner_d = sel;
                    end
                end
            end
            // With lock low the owner either transfers now (gnt follows req)
            // or has abandoned; both release the lock.
            ST_LOCKED: begin
                if (!lock_v[owner_q]) begin
                    state_d  = ST_ARB;
                    rr_ptr_d = ~owner_q;
                end
            end
            default: state_d = ST_ARB;
        endcase

        for (int unsigned p = 0; p < 2; p++) begin
            rvalid_d[p] = gnt_v[p] & ~we_v[p];
            err_d[p]    = gnt_v[p] & ~in_range;
            rdata_d[p]  = rdata_q[p];
            if (gnt_v[p] && !we_v[p]) rdata_d[p] = in_range ? mem_rd : '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_ARB;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '{default: '0};
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid0 = rvalid_q[PORT_CPU];
    assign rvalid1 = rvalid_q[PORT_DMA];
    assign err0    = err_q[PORT_CPU];
    assign err1    = err_q[PORT_DMA];
    assign rdata0  = rdata_q[PORT_CPU];
    assign rdata1  = rdata_q[PORT_DMA];

`ifdef DMEM_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] gnt_cnt_q [2];
    logic [CNT_WIDTH-1:0] gnt_cnt_d [2];
    logic [CNT_WIDTH-1:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            gnt_cnt_d[p] = gnt_cnt_q[p];
            if (gnt_v[p] && !(&gnt_cnt_q[p])) gnt_cnt_d[p] = gnt_cnt_q[p] + 1'b1;
        end
        conflict_cnt_d = conflict_cnt_q;
        if (|(req_v & ~gnt_v) && !(&conflict_cnt_q)) conflict_cnt_d = conflict_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gnt_cnt_q      <= '{default: '0};
            conflict_cnt_q <= '0;
        end else begin
            gnt_cnt_q      <= gnt_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign gnt_cnt0     = gnt_cnt_q[PORT_CPU];
    assign gnt_cnt1     = gnt_cnt_q[PORT_DMA];
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus random traffic
// against a transaction-level model of grants, locking and memory contents.
module tb_dmem_arbiter;

    localparam int DEPTH = 100;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
    logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

    always #5 CLK = ~CLK;

    dmem_arbiter #(.DATA_WIDTH(32), .MEM_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
`ifdef DMEM_ARB_STATS_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .conflict_cnt(conflict_cnt)
`endif
    );

    // Memory device: combinational read, synchronous write.
    logic [31:0] tb_mem  [0:127];
    logic [31:0] ref_mem [0:127];
    always @(posedge CLK) if (mem_we && mem_a < 128) tb_mem[mem_a[6:0]] <= mem_wd;
    assign mem_rd = (mem_a < 128) ? tb_mem[mem_a[6:0]] : 32'h0;

    typedef struct {
        logic        rv;
        logic        er;
        logic [31:0] d;
    } resp_t;
    resp_t exp_q0[$];
    resp_t exp_q1[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: grant rules, lock ownership, memory contents.
    logic       m_locked = 0, m_owner = 0, m_pref = 0;
    logic [1:0] m_took = '0;
    int         m_gc0 = 0, m_gc1 = 0, m_cc = 0;

    always @(negedge CLK) begin : model_blk
        logic [1:0]  r, l, w, g;
        logic        p, inr;
        logic [31:0] a, d;
        resp_t       e;
        if (!RST) begin
            m_locked = 0; m_pref = 0; m_took = '0;
            m_gc0 = 0; m_gc1 = 0; m_cc = 0;
            exp_q0.delete(); exp_q1.delete();
            chk("gnt_in_reset", {30'd0, gnt1, gnt0}, 32'd0);
            chk("mem_we_in_reset", {31'd0, mem_we}, 32'd0);
        end else begin
            r = {req1, req0}; l = {lock1, lock0}; w = {we1, we0};
            g = '0;
            if (m_locked)       g[m_owner] = r[m_owner];
            else if (r == 2'b11) g[m_pref] = 1'b1;
            else                g = r;
            chk("gnt", {30'd0, gnt1, gnt0}, {30'd0, g});
            p   = g[1];
            a   = p ? addr1 : addr0;
            d   = p ? wdata1 : wdata0;
            inr = (a < DEPTH);
            if (r[0] && !g[0] || r[1] && !g[1]) m_cc++;
            if (g != 0) begin
                if (p) m_gc1++; else m_gc0++;
                chk("mem_a", mem_a, a);
                chk("mem_wd", mem_wd, d);
                chk("mem_we", {31'd0, mem_we}, {31'd0, w[p] & inr});
                if (!w[p] || !inr) begin
                    e.rv = !w[p];
                    e.er = !inr;
                    e.d  = (!w[p] && inr) ? ref_mem[a[6:0]] : 32'h0;
                    if (p) exp_q1.push_back(e); else exp_q0.push_back(e);
                end
                if (w[p] && inr) ref_mem[a[6:0]] = d;
                if (!m_locked) m_pref = ~p;
            end else begin
                chk("idle_bus", {mem_a ^ mem_wd, 31'd0} | {31'd0, mem_we} | mem_a, 32'd0);
            end
            if (!m_locked) begin
                if (g != 0 && l[p]) begin m_locked = 1; m_owner = p; end
            end else if ((g[m_owner] && !l[m_owner]) || (!r[m_owner] && !l[m_owner])) begin
                m_locked = 0;
                m_pref   = ~m_owner;
            end
            m_took = g;
        end
    end

    // Monitor: pops an expected response whenever a port shows rvalid/err.
    task automatic mon_port(input int p, input logic rv, input logic er, input logic [31:0] d);
        resp_t e;
        if (rv || er) begin
            if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_resp%0d: got rv=%b err=%b expected none at %0t", p, rv, er, $time);
            end else begin
                e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk($sformatf("rvalid%0d", p), {31'd0, rv}, {31'd0, e.rv});
                chk($sformatf("err%0d", p), {31'd0, er}, {31'd0, e.er});
                if (e.rv) chk($sformatf("rdata%0d", p), d, e.d);
            end
        end
    endtask

    always @(posedge CLK) begin
        #2;
        if (RST) begin
            mon_port(0, rvalid0, err0, rdata0);
            mon_port(1, rvalid1, err1, rdata1);
        end
    end

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_port(input int p, input logic rq, input logic w, input logic lk,
                            input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin req0 = rq; we0 = w; lock0 = lk; addr0 = a; wdata0 = d; end
        else        begin req1 = rq; we1 = w; lock1 = lk; addr1 = a; wdata1 = d; end
    endtask

    task automatic idle_all();
        set_port(0, 0, 0, 0, 0, 0);
        set_port(1, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_pulse();
        next();
        RST = 1'b0;
        idle_all();
        @(posedge CLK);
        #3 RST = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        int k = $urandom_range(0, 19);
        if (k == 0) return 32'hFFFF_FFF0;
        if (k < 3)  return 32'(100 + $urandom_range(0, 27));
        return 32'($urandom_range(0, 15));
    endfunction

    initial begin
        for (int i = 0; i < 128; i++) begin
            tb_mem[i]  = 32'hA500_0000 | 32'(i);
            ref_mem[i] = 32'hA500_0000 | 32'(i);
        end
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
        chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("rst_err0", {31'd0, err0}, 32'd0);
        chk("rst_err1", {31'd0, err1}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        #2 RST = 1'b1;

        // write then read back on port 0
        set_port(0, 1, 1, 0, 5, 32'hDEAD_BEEF);
        next();
        set_port(0, 1, 0, 0, 5, 0);
        next();
        idle_all();
        next();
        chk("rdata0_after_wr_rd", rdata0, 32'hDEAD_BEEF);

        // both ports contend for four reads from reset
        reset_pulse();
        set_port(0, 1, 0, 0, 1, 0);
        set_port(1, 1, 0, 0, 2, 0);
        repeat (4) next();
        idle_all();
        next();

        // port 1 locked read-modify-write while port 0 waits
        set_port(0, 1, 0, 0, 3, 0);
        next();
        set_port(1, 1, 0, 1, 7, 0);
        next();
        set_port(1, 1, 1, 0, 7, 32'h1234_5678);
        next();
        set_port(1, 0, 0, 0, 0, 0);
        next();
        set_port(0, 0, 0, 0, 0, 0);
        set_port(1, 1, 0, 0, 7, 0);
        next();
        idle_all();
        next();
        chk("mem7_after_rmw", rdata1, 32'h1234_5678);

        // out-of-range write then read
        set_port(0, 1, 1, 0, 100, 32'h1);
        next();
        set_port(0, 1, 0, 0, 100, 0);
        next();
        idle_all();
        next();
        chk("rdata0_oor", rdata0, 32'h0);

        // asynchronous reset while port 1 holds a lock with a read in flight
        set_port(1, 1, 0, 1, 9, 0);
        next();
        #2 RST = 1'b0;
        #1;
        chk("async_rst_rvalid1", {31'd0, rvalid1}, 32'd0);
        chk("async_rst_err1", {31'd0, err1}, 32'd0);
        set_port(0, 1, 0, 0, 4, 0);
        set_port(1, 1, 0, 0, 6, 0);
        @(posedge CLK);
        #3 RST = 1'b1;
        @(negedge CLK);
        #1;
        chk("first_gnt0_after_rst", {31'd0, gnt0}, 32'd1);
        next();
        idle_all();
        next();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                logic busy;
                busy = (p == 0) ? req0 : req1;
                if (!busy || m_took[p]) begin
                    if ($urandom_range(0, 3) == 0) set_port(p, 0, 0, 0, 0, 0);
                    else set_port(p, 1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                                  rand_addr(), $urandom());
                end
            end
            next();
        end
        idle_all();
        repeat (4) next();
        chk("pending_q0", exp_q0.size(), 0);
        chk("pending_q1", exp_q1.size(), 0);
`ifdef DMEM_ARB_STATS_EN
        chk("gnt_cnt0", {16'd0, gnt_cnt0}, (m_gc0 > 65535) ? 32'hFFFF : 32'(m_gc0));
        chk("gnt_cnt1", {16'd0, gnt_cnt1}, (m_gc1 > 65535) ? 32'hFFFF : 32'(m_gc1));
        chk("conflict_cnt", {16'd0, conflict_cnt}, (m_cc > 65535) ? 32'hFFFF : 32'(m_cc));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
